sram_req_arbiter: RTL and testbench
===================================

# sram_req_arbiter

Two-master to one-slave arbiter for the SRAM-like request interface. It merges the instruction-fetch port and the data port onto a single SRAM-like slave port, typically the AXI bridge or a shared uncached path. It locks each grant until the address handshake completes and tracks outstanding transactions in an in-order ID FIFO, so it can route `data_ok`/`rdata` back to the issuing master. It sits between the IF/EXE stages and the bridge in the CPU top.

## Interface
- `MAX_OUTSTANDING`, 4: depth of the in-order ID FIFO (power of two, ≥2).
- `STARVE_LIMIT`, 8: cycles m0 may wait while m1 wins before m0 is forced ahead.
- `clk` in 1: the single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `m0_req` / `m0_wr` in 1 each: instruction master request and write flag.
- `m0_size` in 2, `m0_wstrb` in 4, `m0_addr` in 32, `m0_wdata` in 32: instruction master request payload.
- `m0_addr_ok` / `m0_data_ok` out 1 each; `m0_rdata` out 32: instruction master responses.
- `m1_*` (same set): data master.
- `s_req` / `s_wr` out 1 each; `s_size` out 2, `s_wstrb` out 4, `s_addr` out 32, `s_wdata` out 32: request to the slave.
- `s_addr_ok` / `s_data_ok` in 1 each; `s_rdata` in 32: slave responses.
- `flush` in 1: pipeline flush; the arbiter does not cancel transactions on it (see Operation).

## Operation
- FSM states: IDLE, LOCK0, LOCK1.
- **Grant in IDLE.** The grant is combinational when the FIFO is not full.
  - Default priority is m1 > m0.
  - If `starve_cnt ≥ STARVE_LIMIT`, m0 wins instead.
- **Handshake in IDLE.**
  - If the slave asserts `s_addr_ok` the same cycle, the handshake completes and the state stays IDLE.
  - Otherwise the state moves to LOCKn, n being the winner.
- **LOCKn.** Only master n is forwarded to the slave. The state returns to IDLE on `s_addr_ok`.
  - Master n must hold its req/payload stable (SRAM-like rule); the arbiter does not register the payload.
- **Routing.** `s_*` request fields mux from the granted master; they are all zero when no master is granted.
  - `mN_addr_ok = grantN & s_addr_ok`.
- **ID FIFO.**
  - On each accepted request (`s_req & s_addr_ok`), push the master ID (1 bit).
  - On `s_data_ok`, pop; route `s_data_ok`/`s_rdata` to the head ID. Non-head `rdata` is driven to 0.
- **Full/empty.**
  - FIFO full → `s_req=0`, no grant, state held. In LOCKn the full state cannot occur, because the count was checked at grant time.
  - Full with simultaneous push and pop → the pop frees space only the next cycle, so no grant that cycle.
  - `s_data_ok` while the FIFO is empty → ignored, no pop. This is an assertion-worthy protocol error.
- **starve_cnt** (width `$clog2(STARVE_LIMIT)+1`, saturating):
  - increments each cycle m0 requests in IDLE and is not granted;
  - clears when m0 is granted or when `m0_req=0`.
- **flush.** Outstanding transactions are not cancelled; the stages discard stale data themselves. The arbiter's behaviour is identical with or without flush.
- **Reset** (asynchronous, mid-transaction included):
  - state=IDLE, FIFO empty (read/write pointers and count = 0), `starve_cnt=0`.
  - All outputs are 0 while `resetn=0`.

## Timing
- Request path is combinational: `mN_req` → `s_req` in the same cycle. Minimum latency from req to `addr_ok` is 0 cycles beyond the slave's.
- Response path is combinational: `s_data_ok` → `mN_data_ok` in the same cycle.
- Push and pop in the same cycle are both performed; count is unchanged.
- Back-to-back grants every cycle are possible when the slave returns `addr_ok` immediately.
- `addr_ok` for one master and `data_ok` for the other in the same cycle are legal and independent.

## Structure
- Shared package `cpu_bus_pkg` holds:
  - the state encoding: IDLE=2'd0, LOCK0=2'd1, LOCK1=2'd2;
  - the master IDs: ID_INST=1'b0, ID_DATA=1'b1.
- Sub-module `id_fifo` (width 1, depth `MAX_OUTSTANDING`, outputs full/empty/head) is instantiated once.

## Test plan
- **Single master:** m0 read at 0x1C000000, slave `addr_ok` after 2 cycles, `data_ok` after 3 more with rdata 0x02800000 → `m0_addr_ok` pulses once, `m0_data_ok` pulses with rdata 0x02800000, `m1_data_ok` stays 0.
- **Collision:** m0 and m1 both request in the same cycle (m1 store to 0x100, wstrb 4'hF) → m1 granted first. The next cycle m0 is granted. data_ok returns route m1 then m0, in order.
- **Lock:** m0 granted, slave delays `addr_ok` 3 cycles while m1 raises req → `s_addr` stays m0's for all 4 cycles. m1 is granted only after m0's `addr_ok`.
- **FIFO full:** 4 accepted requests with no `data_ok` (`MAX_OUTSTANDING=4`) → the 5th request sees `s_req=0`. One `data_ok` pops, and the next cycle the 5th request is accepted.
- **Starvation:** m1 requests continuously with immediate `addr_ok` and m0 requests continuously → m0 is granted within 9 cycles (`STARVE_LIMIT=8`).
- **Reset:** `resetn` deasserted mid-LOCK1 with 2 outstanding → all outputs 0 immediately. After release, state=IDLE, FIFO empty, and a subsequent stray `s_data_ok` routes to no master.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared types for the SRAM-like CPU bus: arbiter state encoding, master IDs, request payload.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/id_fifo.sv
// Purpose: small in-order FIFO holding the issuing master ID of each outstanding transaction.
// Latency: push visible at head one cycle later; head is read combinationally.
// Backpressure: push ignored when full, pop ignored when empty; space freed by a pop appears next cycle.
module id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_dat;
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Purpose: merge instruction (m0) and data (m1) SRAM-like masters onto one slave, routing responses in order.
// Latency: request and response paths are combinational (0 cycles added).
// Backpressure: grant held until s_addr_ok; no grant while MAX_OUTSTANDING transactions are in flight.
module sram_req_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic [31:0] m1_rdata,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata,
    input  logic        flush
);
    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [SW-1:0] starve_cnt;
    logic          starved;
    logic          grant0;
    logic          grant1;
    logic          fifo_full;
    logic          fifo_empty;
    logic          head_id;
    logic          push;
    logic          pop;
    sram_req_t     m0_pkt;
    sram_req_t     m1_pkt;
    sram_req_t     s_pkt;

    // Stages discard stale responses themselves, so flush has no effect here.
    logic unused_flush;
    assign unused_flush = flush;

    assign starved = (starve_cnt >= SW'(STARVE_LIMIT));

    // Grants are gated by resetn so every output is 0 while reset is asserted.
    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        if (resetn) begin
            case (state)
                IDLE: begin
                    if (!fifo_full) begin
                        if (m0_req && (starved || !m1_req)) grant0 = 1'b1;
                        else if (m1_req)                    grant1 = 1'b1;
                        if (grant0 && !s_addr_ok)      state_nxt = LOCK0;
                        else if (grant1 && !s_addr_ok) state_nxt = LOCK1;
                    end
                end
                LOCK0: begin
                    grant0 = 1'b1;
                    if (s_addr_ok) state_nxt = IDLE;
                end
                LOCK1: begin
                    grant1 = 1'b1;
                    if (s_addr_ok) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (!m0_req || grant0) begin
            starve_cnt <= '0;
        end else if (state == IDLE && starve_cnt != '1) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    assign m0_pkt = {m0_wr, m0_size, m0_wstrb, m0_addr, m0_wdata};
    assign m1_pkt = {m1_wr, m1_size, m1_wstrb, m1_addr, m1_wdata};
    assign s_pkt  = grant1 ? m1_pkt : (grant0 ? m0_pkt : '0);

    assign s_req   = (grant0 & m0_req) | (grant1 & m1_req);
    assign s_wr    = s_pkt.wr;
    assign s_size  = s_pkt.size;
    assign s_wstrb = s_pkt.wstrb;
    assign s_addr  = s_pkt.addr;
    assign s_wdata = s_pkt.wdata;

    assign m0_addr_ok = grant0 & s_addr_ok;
    assign m1_addr_ok = grant1 & s_addr_ok;

    assign push = s_req & s_addr_ok;
    // A data_ok with nothing outstanding is a slave protocol error and is dropped.
    assign pop  = resetn & s_data_ok & ~fifo_empty;

    id_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (push),
        .push_dat (grant1 ? ID_DATA : ID_INST),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head_id)
    );

    assign m0_data_ok = pop & (head_id == ID_INST);
    assign m1_data_ok = pop & (head_id == ID_DATA);
    assign m0_rdata   = m0_data_ok ? s_rdata : '0;
    assign m1_rdata   = m1_data_ok ? s_rdata : '0;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench: stimulus pushes expected addr_ok/data_ok events into queues; a monitor pops and compares.
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_req, m0_wr, m0_addr_ok, m0_data_ok;
    logic [1:0]  m0_size;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_wr, m1_addr_ok, m1_data_ok;
    logic [1:0]  m1_size;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        s_req, s_wr, s_addr_ok, s_data_ok;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        flush;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic        id;
        logic [31:0] val;
    } exp_t;

    exp_t addr_q[$];
    exp_t data_q[$];

    always #5 clk = ~clk;

    sram_req_arbiter #(
        .MAX_OUTSTANDING (4),
        .STARVE_LIMIT    (8)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .m0_req     (m0_req),
        .m0_wr      (m0_wr),
        .m0_size    (m0_size),
        .m0_wstrb   (m0_wstrb),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_addr_ok (m0_addr_ok),
        .m0_data_ok (m0_data_ok),
        .m0_rdata   (m0_rdata),
        .m1_req     (m1_req),
        .m1_wr      (m1_wr),
        .m1_size    (m1_size),
        .m1_wstrb   (m1_wstrb),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_addr_ok (m1_addr_ok),
        .m1_data_ok (m1_data_ok),
        .m1_rdata   (m1_rdata),
        .s_req      (s_req),
        .s_wr       (s_wr),
        .s_size     (s_size),
        .s_wstrb    (s_wstrb),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_addr_ok  (s_addr_ok),
        .s_data_ok  (s_data_ok),
        .s_rdata    (s_rdata),
        .flush      (flush)
    );

    task automatic expect_eq(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [159:0] all_outs();
        return {20'd0, m0_addr_ok, m0_data_ok, m0_rdata, m1_addr_ok, m1_data_ok, m1_rdata,
                s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata};
    endfunction

    task automatic exp_addr(input logic id, input logic [31:0] val);
        exp_t e;
        e.id = id;
        e.val = val;
        addr_q.push_back(e);
    endtask

    task automatic exp_data(input logic id, input logic [31:0] val);
        exp_t e;
        e.id = id;
        e.val = val;
        data_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake must match the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (m0_addr_ok || m1_addr_ok) begin
                if (addr_q.size() == 0) begin
                    expect_eq("unexpected_addr_ok", {m1_addr_ok, m0_addr_ok, s_addr}, 160'd0);
                end else begin
                    e = addr_q.pop_front();
                    expect_eq("addr_ok_route", {m1_addr_ok, m0_addr_ok, s_addr}, {e.id, ~e.id, e.val});
                end
            end
            if (m0_data_ok || m1_data_ok) begin
                if (data_q.size() == 0) begin
                    expect_eq("unexpected_data_ok", {m1_data_ok, m0_data_ok, m0_rdata, m1_rdata}, 160'd0);
                end else begin
                    e = data_q.pop_front();
                    expect_eq("data_ok_route", {m1_data_ok, m0_data_ok, m0_rdata, m1_rdata},
                              {e.id, ~e.id, (e.id ? 32'd0 : e.val), (e.id ? e.val : 32'd0)});
                end
            end
        end
    end

    initial begin : stimulus
        resetn = 1'b0; flush = 1'b0;
        m0_req = 1'b0; m0_wr = 1'b0; m0_size = 2'd2; m0_wstrb = 4'h0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_size = 2'd2; m1_wstrb = 4'h0; m1_addr = '0; m1_wdata = '0;
        s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;

        // Reset: outputs stay 0 even with requests and slave strobes present
        tick();
        m0_req = 1'b1; m0_addr = 32'h1C00_0000; s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'h1234_5678;
        @(negedge clk);
        expect_eq("reset_outputs_zero", all_outs(), 160'd0);
        tick();
        m0_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0; resetn = 1'b1;
        @(negedge clk);
        expect_eq("idle_no_req", all_outs(), 160'd0);

        // Single master: addr_ok after 2 wait cycles, data_ok 3 cycles later
        tick();
        m0_req = 1'b1; m0_addr = 32'h1C00_0000;
        @(negedge clk);
        expect_eq("t1_req_forward", {s_req, s_wr, s_addr}, {1'b1, 1'b0, 32'h1C00_0000});
        tick();
        @(negedge clk);
        expect_eq("t1_req_held", {s_req, s_addr}, {1'b1, 32'h1C00_0000});
        tick();
        s_addr_ok = 1'b1; exp_addr(1'b0, 32'h1C00_0000);
        tick();
        m0_req = 1'b0; s_addr_ok = 1'b0;
        tick();
        tick();
        s_data_ok = 1'b1; s_rdata = 32'h0280_0000; exp_data(1'b0, 32'h0280_0000);
        tick();
        s_data_ok = 1'b0;

        // Collision: m1 store wins, m0 next cycle; m1 response overlaps m0 addr_ok
        tick();
        flush = 1'b1;
        m0_req = 1'b1; m0_addr = 32'h0000_0200;
        m1_req = 1'b1; m1_wr = 1'b1; m1_wstrb = 4'hF; m1_addr = 32'h0000_0100; m1_wdata = 32'hDEAD_BEEF;
        s_addr_ok = 1'b1; exp_addr(1'b1, 32'h0000_0100);
        @(negedge clk);
        expect_eq("t2_m1_store_payload", {s_wr, s_wstrb, s_wdata}, {1'b1, 4'hF, 32'hDEAD_BEEF});
        tick();
        m1_req = 1'b0; m1_wr = 1'b0; m1_wstrb = 4'h0;
        exp_addr(1'b0, 32'h0000_0200);
        s_data_ok = 1'b1; s_rdata = 32'h1111_1111; exp_data(1'b1, 32'h1111_1111);
        tick();
        m0_req = 1'b0; s_addr_ok = 1'b0;
        s_rdata = 32'h2222_2222; exp_data(1'b0, 32'h2222_2222);
        tick();
        s_data_ok = 1'b0; flush = 1'b0;

        // Lock: m0 held for 4 cycles while m1 waits
        tick();
        m0_req = 1'b1; m0_addr = 32'h0000_0300;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin m1_req = 1'b1; m1_addr = 32'h0000_0400; end
            if (i == 3) begin s_addr_ok = 1'b1; exp_addr(1'b0, 32'h0000_0300); end
            @(negedge clk);
            expect_eq("t3_lock_addr", {s_req, s_addr}, {1'b1, 32'h0000_0300});
            if (i < 3) tick();
        end
        tick();
        m0_req = 1'b0; exp_addr(1'b1, 32'h0000_0400);
        @(negedge clk);
        expect_eq("t3_m1_after_lock", {s_req, s_addr}, {1'b1, 32'h0000_0400});
        tick();
        m1_req = 1'b0; s_addr_ok = 1'b0;
        s_data_ok = 1'b1; s_rdata = 32'h3333_3333; exp_data(1'b0, 32'h3333_3333);
        tick();
        s_rdata = 32'h4444_4444; exp_data(1'b1, 32'h4444_4444);
        tick();
        s_data_ok = 1'b0;

        // FIFO full: 4 outstanding blocks the 5th until a pop has taken effect
        for (int i = 0; i < 4; i++) begin
            tick();
            m1_req = 1'b1; m1_addr = 32'h0000_0500 + 32'(4 * i); s_addr_ok = 1'b1;
            exp_addr(1'b1, m1_addr);
        end
        tick();
        m1_addr = 32'h0000_0510;
        @(negedge clk);
        expect_eq("t4_full_no_req", {s_req, s_addr}, 160'd0);
        tick();
        s_data_ok = 1'b1; s_rdata = 32'h0000_00A0; exp_data(1'b1, 32'h0000_00A0);
        @(negedge clk);
        expect_eq("t4_full_pop_same_cycle", s_req, 160'd0);
        tick();
        s_data_ok = 1'b0; exp_addr(1'b1, 32'h0000_0510);
        @(negedge clk);
        expect_eq("t4_fifth_accepted", {s_req, s_addr}, {1'b1, 32'h0000_0510});
        tick();
        m1_req = 1'b0; s_addr_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            s_data_ok = 1'b1; s_rdata = 32'h0000_00A1 + 32'(i); exp_data(1'b1, s_rdata);
        end
        tick();
        s_data_ok = 1'b0;

        // Starvation: m1 wins 8 times, m0 forced ahead on the 9th cycle
        for (int k = 0; k < 9; k++) begin
            tick();
            m0_req = 1'b1; m0_addr = 32'h0000_0700;
            m1_req = 1'b1; m1_addr = 32'h0000_0600; s_addr_ok = 1'b1;
            if (k < 8) exp_addr(1'b1, 32'h0000_0600);
            else       exp_addr(1'b0, 32'h0000_0700);
            if (k > 0) begin
                s_data_ok = 1'b1; s_rdata = 32'h0000_0100 + 32'(k); exp_data(1'b1, s_rdata);
            end
        end
        tick();
        m0_req = 1'b0; m1_req = 1'b0; s_addr_ok = 1'b0;
        s_data_ok = 1'b1; s_rdata = 32'h0000_01FF; exp_data(1'b0, 32'h0000_01FF);
        tick();
        s_data_ok = 1'b0;

        // Reset mid-LOCK1 with 2 outstanding
        tick();
        m1_req = 1'b1; m1_addr = 32'h0000_0800; s_addr_ok = 1'b1; exp_addr(1'b1, 32'h0000_0800);
        tick();
        m1_addr = 32'h0000_0804; exp_addr(1'b1, 32'h0000_0804);
        tick();
        m1_addr = 32'h0000_0808; s_addr_ok = 1'b0;
        @(negedge clk);
        expect_eq("t6_lock1_forward", {s_req, s_addr}, {1'b1, 32'h0000_0808});
        tick();
        resetn = 1'b0; m0_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'h0000_DEAD;
        #1;
        expect_eq("t6_async_reset_outs", all_outs(), 160'd0);
        @(negedge clk);
        expect_eq("t6_reset_hold_outs", all_outs(), 160'd0);
        tick();
        m0_req = 1'b0; m1_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0; resetn = 1'b1;
        tick();
        s_data_ok = 1'b1; s_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        expect_eq("t6_stray_data_ok", {m0_data_ok, m1_data_ok, m0_rdata, m1_rdata}, 160'd0);
        tick();
        s_data_ok = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h0000_0900; s_addr_ok = 1'b1; exp_addr(1'b0, 32'h0000_0900);
        tick();
        m0_req = 1'b0; s_addr_ok = 1'b0;
        s_data_ok = 1'b1; s_rdata = 32'h0000_CAFE; exp_data(1'b0, 32'h0000_CAFE);
        tick();
        s_data_ok = 1'b0;
        repeat (3) tick();

        expect_eq("addr_q_drained", 160'(addr_q.size()), 160'd0);
        expect_eq("data_q_drained", 160'(data_q.size()), 160'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
